// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM states, key-index field positions and the
// key-index-to-digit map used by the emulator, the lock and the sequence bench.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } key_state_t;

    // key_idx = {row, col}
    localparam int ROW_MSB = 3;
    localparam int ROW_LSB = 2;
    localparam int COL_MSB = 1;
    localparam int COL_LSB = 0;

    // Digit codes for the two non-numeric keys on the bottom row
    localparam logic [3:0] DIGIT_STAR = 4'hE;
    localparam logic [3:0] DIGIT_HASH = 4'hF;

    // Nibble n holds the digit printed on key index n. Layout, row 0 on top:
    //   1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    localparam logic [63:0] KEY_DIGIT_MAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_to_digit(input logic [3:0] idx);
        return KEY_DIGIT_MAP[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_press_timer.sv
// Loadable down-counter shared by the HOLD and GAP phases. tc is high on the
// last enabled cycle of a loaded interval, so loading N yields N enabled cycles.
module keypad_press_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // Load takes priority so a phase change can reload on its terminal cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = en && (count == CNT_W'(1));

endmodule

// File: rtl/keypad_matrix_emulator.sv
// 4x4 matrix keypad model: presses one queued key at a time for HOLD_CYCLES,
// echoes the pressed column's scan onto the key's row, then releases for
// GAP_CYCLES before accepting the next key.
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES = 64,
    parameter int GAP_CYCLES  = 32,
    parameter int HIT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       scan,
    output logic [3:0]       code,
    input  logic             key_valid,
    input  logic [3:0]       key_idx,
    output logic             key_ready,
    input  logic             abort,
    output logic             busy,
    output logic             press_done,
    output logic [HIT_W-1:0] hits
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    key_state_t       state;
    key_state_t       state_next;
    logic [1:0]       row_q;
    logic [1:0]       col_q;
    logic [3:0]       code_next;
    logic             accept;
    logic             end_press;
    logic             timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic             timer_en;
    logic             timer_tc;
    logic             hit;

    keypad_press_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (timer_load),
        .load_val (timer_load_val),
        .en       (timer_en),
        .tc       (timer_tc)
    );

    // State register; reset dominates everything including an active press
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, timer control and row drive; abort releases the key at once
    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        end_press      = 1'b0;
        timer_load     = 1'b0;
        timer_load_val = CNT_W'(HOLD_CYCLES);
        timer_en       = 1'b0;
        code_next      = '0;
        case (state)
            IDLE: begin
                if (key_valid) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    state_next = PRESS;
                end
            end
            PRESS: begin
                timer_en         = 1'b1;
                code_next[row_q] = scan[col_q];
                if (abort || timer_tc) begin
                    end_press      = 1'b1;
                    timer_load     = 1'b1;
                    timer_load_val = CNT_W'(GAP_CYCLES);
                    state_next     = GAP;
                    if (abort) begin
                        code_next = '0;
                    end
                end
            end
            GAP: begin
                timer_en = 1'b1;
                if (timer_tc) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign key_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign hit       = (state == PRESS) && scan[col_q];

    // Latched key, registered row sense, completion pulse and saturating hit count
    always_ff @(posedge CLK) begin
        if (!RST) begin
            row_q      <= '0;
            col_q      <= '0;
            code       <= '0;
            press_done <= 1'b0;
            hits       <= '0;
        end else begin
            code       <= code_next;
            press_done <= end_press;
            if (accept) begin
                row_q <= key_idx[ROW_MSB:ROW_LSB];
                col_q <= key_idx[COL_MSB:COL_LSB];
                hits  <= '0;
            end else if (hit && (hits != '1)) begin
                hits <= hits + HIT_W'(1);
            end
        end
    end

endmodule
